// File: rtl/seq_alu_core_if.sv
// Start/busy/done handshake bundle between the calculator select logic and seq_alu_core.
// The master drives the request and operands; the slave returns status and result.
interface seq_alu_core_if #(
    parameter int N = 8
);
    logic           start;
    logic [1:0]     op;
    logic [N-1:0]   a;
    logic [N-1:0]   b;
    logic           busy;
    logic           done;
    logic [2*N-1:0] result;
    logic           ovf;
    logic           dbz;

    modport master (
        output start, op, a, b,
        input  busy, done, result, ovf, dbz
    );

    modport slave (
        input  start, op, a, b,
        output busy, done, result, ovf, dbz
    );
endinterface

// File: rtl/seq_alu_core.sv
// Multi-cycle unsigned ALU: single-cycle add/sub, shift-add multiply and restoring divide.
// One 2N accumulator serves both iterative ops; all outputs are registered.
module seq_alu_core #(
    parameter int N  = 8,
    parameter int CW = 4
) (
    input logic          Clk,
    input logic          Rst,
    seq_alu_core_if.slave bus
);
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_MUL = 2'b01;
    localparam logic [1:0] OP_DIV = 2'b10;
    localparam logic [1:0] OP_SUB = 2'b11;

    state_t         r_state;
    state_t         w_next;
    logic [CW-1:0]  r_cnt;
    logic [1:0]     r_op;
    logic [N-1:0]   r_a;
    logic [N-1:0]   r_b;
    logic [2*N-1:0] r_acc;
    logic           r_busy;
    logic           r_done;
    logic [2*N-1:0] r_result;
    logic           r_ovf;
    logic           r_dbz;

    logic           w_accept;
    logic           w_needs_calc;
    logic [N:0]     w_sum;
    logic [N:0]     w_diff;
    logic [N:0]     w_mul_sum;
    logic [2*N:0]   w_shift;
    logic           w_div_ge;
    logic [N-1:0]   w_trial;
    logic [2*N-1:0] w_iter_acc;
    logic [2*N-1:0] w_res;
    logic           w_res_ovf;
    logic           w_res_dbz;

    assign w_accept     = (r_state == S_IDLE) && bus.start;
    assign w_needs_calc = (bus.op == OP_MUL) || ((bus.op == OP_DIV) && (bus.b != {N{1'b0}}));

    assign w_sum     = {1'b0, r_a} + {1'b0, r_b};
    assign w_diff    = {1'b0, r_a} - {1'b0, r_b};
    assign w_mul_sum = {1'b0, r_acc[2*N-1:N]} + {1'b0, r_a};
    assign w_shift   = {r_acc, 1'b0};
    // Remainder stays below the divisor, so the N-bit wrapped difference is exact when kept.
    assign w_div_ge  = (w_shift[2*N:N] >= {1'b0, r_b});
    assign w_trial   = w_shift[2*N-1:N] - r_b;

    // State register
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state decode
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (bus.start) begin
                    w_next = w_needs_calc ? S_CALC : S_DONE;
                end else begin
                    w_next = S_IDLE;
                end
            end
            S_CALC: begin
                if (r_cnt == CW'(1)) begin
                    w_next = S_DONE;
                end else begin
                    w_next = S_CALC;
                end
            end
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // One multiply or divide iteration on the shared accumulator
    always_comb begin
        w_iter_acc = r_acc;
        case (r_op)
            OP_MUL: begin
                if (r_acc[0]) begin
                    w_iter_acc = {w_mul_sum, r_acc[N-1:1]};
                end else begin
                    w_iter_acc = {1'b0, r_acc[2*N-1:1]};
                end
            end
            OP_DIV: begin
                if (w_div_ge) begin
                    w_iter_acc = {w_trial, w_shift[N-1:1], 1'b1};
                end else begin
                    w_iter_acc = w_shift[2*N-1:0];
                end
            end
            default: w_iter_acc = r_acc;
        endcase
    end

    // Final result and flags selected by the latched op
    always_comb begin
        w_res     = {2*N{1'b0}};
        w_res_ovf = 1'b0;
        w_res_dbz = 1'b0;
        case (r_op)
            OP_ADD: begin
                w_res     = {{(N-1){1'b0}}, w_sum};
                w_res_ovf = w_sum[N];
            end
            OP_SUB: begin
                w_res     = {{N{1'b0}}, w_diff[N-1:0]};
                w_res_ovf = w_diff[N];
            end
            OP_MUL: w_res = r_acc;
            OP_DIV: begin
                if (r_b == {N{1'b0}}) begin
                    w_res     = {r_a, {N{1'b1}}};
                    w_res_dbz = 1'b1;
                end else begin
                    w_res     = r_acc;
                end
            end
            default: w_res = {2*N{1'b0}};
        endcase
    end

    // Operand latch, iteration counter and accumulator
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            r_op  <= 2'b00;
            r_a   <= {N{1'b0}};
            r_b   <= {N{1'b0}};
            r_cnt <= {CW{1'b0}};
            r_acc <= {2*N{1'b0}};
        end else if (w_accept) begin
            r_op  <= bus.op;
            r_a   <= bus.a;
            r_b   <= bus.b;
            r_cnt <= CW'(N);
            r_acc <= (bus.op == OP_DIV) ? {{N{1'b0}}, bus.a} : {{N{1'b0}}, bus.b};
        end else if (r_state == S_CALC) begin
            r_cnt <= r_cnt - CW'(1);
            r_acc <= w_iter_acc;
        end else begin
            r_cnt <= r_cnt;
            r_acc <= r_acc;
        end
    end

    // Registered handshake, result and flags
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_result <= {2*N{1'b0}};
            r_ovf    <= 1'b0;
            r_dbz    <= 1'b0;
        end else if (r_state == S_DONE) begin
            r_busy   <= 1'b0;
            r_done   <= 1'b1;
            r_result <= w_res;
            r_ovf    <= w_res_ovf;
            r_dbz    <= w_res_dbz;
        end else if (w_accept) begin
            r_busy <= 1'b1;
            r_done <= 1'b0;
        end else begin
            r_done <= 1'b0;
        end
    end

    assign bus.busy   = r_busy;
    assign bus.done   = r_done;
    assign bus.result = r_result;
    assign bus.ovf    = r_ovf;
    assign bus.dbz    = r_dbz;
endmodule
